countdown_timer: RTL and testbench

Loadable down-counting timer with a start/pause/abort control interface and a one-cycle `done` strobe on expiry. It complements the team's up-counters and is used wherever a controller must wait a programmed number of ticks: round timers, move timeouts, display hold periods. An internal prescaler sets how many clock cycles make one tick.

---
 rtl/countdown_timer_pkg.sv | 17 +
 rtl/countdown_timer_if.sv | 24 ++
 rtl/countdown_timer_tick_prescaler.sv | 30 +++
 rtl/countdown_timer.sv | 86 ++++++++
 tb/tb_countdown_timer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and helpers for the countdown timer: FSM state encoding and
// the prescaler width calculation.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_HOLD    = 2'b10,
        ST_EXPIRED = 2'b11
    } state_t;

    // max(1, clog2(prescale))
    function automatic int prescaler_width(input int unsigned prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer: start/pause/abort controls in,
// count and status flags out.
interface countdown_timer_if #(
    parameter int unsigned bits = 4
);
    logic            start;
    logic [bits-1:0] load_value;
    logic            pause;
    logic            abort;
    logic [bits-1:0] count;
    logic            busy;
    logic            expired;
    logic            done;

    modport master (
        output start, load_value, pause, abort,
        input  count, busy, expired, done
    );

    modport slave (
        input  start, load_value, pause, abort,
        output count, busy, expired, done
    );
endinterface

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides enabled clock cycles by `prescale`; `tick` marks the enabled cycle
// that completes a period.
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned prescale = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = prescaler_width(prescale);
    localparam logic [W-1:0] LAST = W'(prescale - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with start/pause/abort control and a one-cycle
// done strobe on expiry; one decrement per `prescale` unpaused cycles.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned bits     = 4,
    parameter int unsigned prescale = 1
) (
    input  logic             clk,
    input  logic             rst,
    countdown_timer_if.slave bus
);
    state_t          state, state_n;
    logic [bits-1:0] count_q, count_n;
    logic            done_q, done_n;
    logic            tick;
    logic            active;

    assign active = (state == ST_RUN) || (state == ST_HOLD);

    // A HOLD cycle with pause released already counts as a run cycle, so each
    // paused cycle delays expiry by exactly one cycle.
    tick_prescaler #(.prescale(prescale)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (active && !bus.pause && !bus.abort && !bus.start),
        .clr  (bus.abort || bus.start),
        .tick (tick)
    );

    always_comb begin
        state_n = state;
        count_n = count_q;
        done_n  = 1'b0;
        if (bus.abort) begin
            state_n = ST_IDLE;
            count_n = '0;
        end else if (bus.start) begin
            count_n = bus.load_value;
            if (bus.load_value == '0) begin
                state_n = ST_EXPIRED;
                done_n  = 1'b1;
            end else if (bus.pause) begin
                state_n = ST_HOLD;
            end else begin
                state_n = ST_RUN;
            end
        end else begin
            unique case (state)
                ST_RUN, ST_HOLD: begin
                    if (bus.pause) begin
                        state_n = ST_HOLD;
                    end else begin
                        state_n = ST_RUN;
                        if (tick) begin
                            count_n = count_q - 1'b1;
                            if (count_q == bits'(1)) begin
                                state_n = ST_EXPIRED;
                                done_n  = 1'b1;
                            end
                        end
                    end
                end
                ST_EXPIRED: count_n = '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            count_q <= count_n;
            done_q  <= done_n;
        end
    end

    assign bus.count   = count_q;
    assign bus.busy    = active;
    assign bus.expired = (state == ST_EXPIRED);
    assign bus.done    = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: three timers (prescale 1, 4, 2) driven in lockstep and
// compared against an elapsed-cycle reference model plus directed expectations.
module tb_countdown_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    countdown_timer_if #(.bits(4)) bus0 ();
    countdown_timer_if #(.bits(4)) bus1 ();
    countdown_timer_if #(.bits(4)) bus2 ();

    countdown_timer #(.bits(4), .prescale(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    countdown_timer #(.bits(4), .prescale(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    countdown_timer #(.bits(4), .prescale(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic [3:0] o_count [3];
    logic       o_busy  [3];
    logic       o_exp   [3];
    logic       o_done  [3];
    assign o_count[0] = bus0.count;  assign o_busy[0] = bus0.busy;
    assign o_exp[0]   = bus0.expired; assign o_done[0] = bus0.done;
    assign o_count[1] = bus1.count;  assign o_busy[1] = bus1.busy;
    assign o_exp[1]   = bus1.expired; assign o_done[1] = bus1.done;
    assign o_count[2] = bus2.count;  assign o_busy[2] = bus2.busy;
    assign o_exp[2]   = bus2.expired; assign o_done[2] = bus2.done;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model: remaining ticks = N - floor(running_cycles / P).
    typedef enum {M_IDLE, M_ACTIVE, M_PAUSED, M_EXP} mmode_t;
    int     per       [3] = '{1, 4, 2};
    mmode_t m_mode    [3];
    int     m_n       [3];
    int     m_elapsed [3];
    int     m_count   [3];
    bit     m_done    [3];

    function automatic void model_step(bit rs, bit st, int ld, bit pa, bit ab);
        for (int i = 0; i < 3; i++) begin
            m_done[i] = 1'b0;
            if (rs || ab) begin
                m_mode[i]  = M_IDLE;
                m_count[i] = 0;
            end else if (st) begin
                m_n[i]       = ld;
                m_elapsed[i] = 0;
                m_count[i]   = ld;
                if (ld == 0) begin
                    m_mode[i] = M_EXP;
                    m_done[i] = 1'b1;
                end else begin
                    m_mode[i] = pa ? M_PAUSED : M_ACTIVE;
                end
            end else if (m_mode[i] == M_ACTIVE || m_mode[i] == M_PAUSED) begin
                if (pa) begin
                    m_mode[i] = M_PAUSED;
                end else begin
                    m_elapsed[i]++;
                    m_count[i] = m_n[i] - m_elapsed[i] / per[i];
                    m_mode[i]  = M_ACTIVE;
                    if (m_count[i] == 0) begin
                        m_mode[i] = M_EXP;
                        m_done[i] = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs to all three timers, then check them against the model.
    task automatic step(input bit st, input int ld, input bit pa, input bit ab, input bit rs);
        rst = rs;
        bus0.start = st; bus0.load_value = 4'(ld); bus0.pause = pa; bus0.abort = ab;
        bus1.start = st; bus1.load_value = 4'(ld); bus1.pause = pa; bus1.abort = ab;
        bus2.start = st; bus2.load_value = 4'(ld); bus2.pause = pa; bus2.abort = ab;
        @(posedge clk);
        model_step(rs, st, ld, pa, ab);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_count[%0d]", i), 32'(o_count[i]), 32'(m_count[i]));
            chk($sformatf("model_busy[%0d]", i), 32'(o_busy[i]),
                32'(m_mode[i] == M_ACTIVE || m_mode[i] == M_PAUSED));
            chk($sformatf("model_expired[%0d]", i), 32'(o_exp[i]), 32'(m_mode[i] == M_EXP));
            chk($sformatf("model_done[%0d]", i), 32'(o_done[i]), 32'(m_done[i]));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset for two cycles
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("reset_count", 32'(bus0.count), 0);
        chk("reset_busy", 32'(bus0.busy), 0);
        chk("reset_expired", 32'(bus0.expired), 0);
        chk("reset_done", 32'(bus0.done), 0);

        // Basic run, prescale 1, load 5
        step(1'b1, 5, 1'b0, 1'b0, 1'b0);
        chk("basic_load", 32'(bus0.count), 5);
        for (int k = 1; k <= 5; k++) begin
            idle(1);
            chk($sformatf("basic_count_e%0d", k), 32'(bus0.count), 32'(5 - k));
            chk($sformatf("basic_done_e%0d", k), 32'(bus0.done), 32'(k == 5));
        end
        idle(1);
        chk("basic_done_after", 32'(bus0.done), 0);
        chk("basic_expired_after", 32'(bus0.expired), 1);
        chk("basic_busy_after", 32'(bus0.busy), 0);

        // Prescale 4, load 3: decrements at edges 4, 8, 12
        step(1'b1, 3, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            idle(1);
            chk($sformatf("pre4_count_e%0d", k), 32'(bus1.count), 32'(3 - k / 4));
            chk($sformatf("pre4_done_e%0d", k), 32'(bus1.done), 32'(k == 12));
        end

        // Pause for 3 cycles at count 2: expiry moves from edge 4 to edge 7
        step(1'b1, 4, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("pause_pre", 32'(bus0.count), 2);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("pause_count_%0d", k), 32'(bus0.count), 2);
            chk($sformatf("pause_busy_%0d", k), 32'(bus0.busy), 1);
        end
        idle(1);
        chk("pause_resume_count", 32'(bus0.count), 1);
        chk("pause_resume_done", 32'(bus0.done), 0);
        idle(1);
        chk("pause_expiry_done", 32'(bus0.done), 1);
        chk("pause_expiry_count", 32'(bus0.count), 0);

        // Zero load
        step(1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("zero_done", 32'(bus0.done), 1);
        chk("zero_expired", 32'(bus0.expired), 1);
        idle(2);

        // Restart mid-run at count 3 (prescale 1); prescale-4 timer restarts its period
        step(1'b1, 7, 1'b0, 1'b0, 1'b0);
        idle(4);
        chk("restart_pre", 32'(bus0.count), 3);
        step(1'b1, 7, 1'b0, 1'b0, 1'b0);
        chk("restart_load", 32'(bus0.count), 7);
        for (int k = 1; k <= 4; k++) begin
            idle(1);
            chk($sformatf("restart_p1_e%0d", k), 32'(bus0.count), 32'(7 - k));
            chk($sformatf("restart_p4_e%0d", k), 32'(bus1.count), 32'(k == 4 ? 6 : 7));
        end

        // Abort at count 2
        step(1'b1, 5, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("abort_pre", 32'(bus0.count), 2);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("abort_count", 32'(bus0.count), 0);
        chk("abort_busy", 32'(bus0.busy), 0);
        chk("abort_expired", 32'(bus0.expired), 0);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk($sformatf("abort_no_done_%0d", k), 32'(bus0.done), 0);
        end

        // Reset mid-run at count 2
        step(1'b1, 5, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("rst_count", 32'(bus0.count), 0);
        chk("rst_busy", 32'(bus0.busy), 0);
        chk("rst_expired", 32'(bus0.expired), 0);
        chk("rst_done", 32'(bus0.done), 0);
        idle(3);
        chk("rst_idle_count", 32'(bus0.count), 0);

        // Prescale 2, load 1: expires at edge 2 unless aborted on that edge
        step(1'b1, 1, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("p2_expiry_done", 32'(bus2.done), 1);
        step(1'b1, 1, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("coinc_done", 32'(bus2.done), 0);
        chk("coinc_busy", 32'(bus2.busy), 0);
        chk("coinc_expired", 32'(bus2.expired), 0);
        chk("coinc_count", 32'(bus2.count), 0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 11) == 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 79) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
